operand_fetch_stage: RTL and testbench

//  Decode->execute operand stage. Drives the register file's two read addresses and takes its

---
 rtl/opfetch_pkg.sv | 14 +
 rtl/opfetch_fwd_mux.sv | 58 +++++
 rtl/operand_fetch_stage.sv | 116 +++++++++++
 tb/tb_operand_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/opfetch_pkg.sv
// rtl/opfetch_pkg.sv - shared constants and bypass-select encoding for the operand fetch stage
package opfetch_pkg;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int         DATA_W   = 32;

   typedef enum logic [1:0] {
      FWD_ZERO,
      FWD_MEM,
      FWD_WB,
      FWD_RF
   } fwd_sel_t;

endpackage

// File: rtl/opfetch_fwd_mux.sv
// rtl/opfetch_fwd_mux.sv - one operand's bypass select and hazard detect
// OPFETCH_MEM_FWD_EN defined: EX/MEM ALU results bypass; otherwise any EX/MEM match stalls
module opfetch_fwd_mux
   import opfetch_pkg::*;
(
   input  logic              usesReg,
   input  logic [4:0]        regNum,
   input  logic [DATA_W-1:0] rfData,
   input  logic              wbEn,
   input  logic [4:0]        wbDr,
   input  logic [DATA_W-1:0] wbData,
   input  logic              memEn,
   input  logic [4:0]        memDr,
   input  logic [DATA_W-1:0] memData,
   input  logic              memIsLoad,
   output logic [DATA_W-1:0] operand,
   output logic              hazard
);

`ifdef OPFETCH_MEM_FWD_EN
   localparam logic MEM_FWD = 1'b1;
`else
   localparam logic MEM_FWD = 1'b0;
`endif

   fwd_sel_t sel;
   logic     notZero;
   logic     memHit;
   logic     wbHit;

   // r0 is hard-wired, so it never matches a producer and never stalls
   always_comb begin
      notZero = (regNum != REG_ZERO);
      memHit  = notZero && memEn && (memDr == regNum);
      wbHit   = notZero && wbEn && (wbDr == regNum);
      sel     = FWD_RF;
      if (!notZero)
         sel = FWD_ZERO;
      else if (memHit && MEM_FWD && !memIsLoad)
         sel = FWD_MEM;
      else if (wbHit)
         sel = FWD_WB;
   end

   always_comb begin
      operand = rfData;
      case (sel)
         FWD_ZERO: operand = '0;
         FWD_MEM:  operand = memData;
         FWD_WB:   operand = wbData;
         default:  operand = rfData;
      endcase
   end

   // A load's value is not ready in EX/MEM; without the mem bypass nothing there is usable
   assign hazard = usesReg && memHit && (memIsLoad || !MEM_FWD);

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - ID/EX operand fetch with wb/EX-MEM bypass and one-entry pipeline register
// OPFETCH_MEM_FWD_EN defined: EX/MEM ALU results bypass; only loads stall
module operand_fetch_stage
   import opfetch_pkg::*;
#(
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic              in_uses_rs,
   input  logic              in_uses_rt,
   input  logic [4:0]        in_rd,
   input  logic [31:0]       in_imm,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic [4:0]        rf_ra,
   output logic [4:0]        rf_rb,
   input  logic [31:0]       rf_adata,
   input  logic [31:0]       rf_bdata,
   input  logic              wb_en,
   input  logic [4:0]        wb_dr,
   input  logic [31:0]       wb_data,
   input  logic              mem_en,
   input  logic [4:0]        mem_dr,
   input  logic [31:0]       mem_data,
   input  logic              mem_is_load,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_a,
   output logic [31:0]       out_b,
   output logic [4:0]        out_rd,
   output logic [31:0]       out_imm,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [DATA_W-1:0] opA;
   logic [DATA_W-1:0] opB;
   logic              hazA;
   logic              hazB;
   logic              haz;
   logic              accept;

   assign rf_ra = in_rs;
   assign rf_rb = in_rt;

   opfetch_fwd_mux u_fwd_rs (
      .usesReg   (in_uses_rs),
      .regNum    (in_rs),
      .rfData    (rf_adata),
      .wbEn      (wb_en),
      .wbDr      (wb_dr),
      .wbData    (wb_data),
      .memEn     (mem_en),
      .memDr     (mem_dr),
      .memData   (mem_data),
      .memIsLoad (mem_is_load),
      .operand   (opA),
      .hazard    (hazA)
   );

   opfetch_fwd_mux u_fwd_rt (
      .usesReg   (in_uses_rt),
      .regNum    (in_rt),
      .rfData    (rf_bdata),
      .wbEn      (wb_en),
      .wbDr      (wb_dr),
      .wbData    (wb_data),
      .memEn     (mem_en),
      .memDr     (mem_dr),
      .memData   (mem_data),
      .memIsLoad (mem_is_load),
      .operand   (opB),
      .hazard    (hazB)
   );

   assign haz      = in_valid && (hazA || hazB);
   assign in_ready = !flush && !haz && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Operands are captured once at accept; a held entry is never re-forwarded
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_a     <= '0;
         out_b     <= '0;
         out_rd    <= '0;
         out_imm   <= '0;
         out_ctrl  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_a     <= opA;
         out_b     <= opB;
         out_rd    <= in_rd;
         out_imm   <= in_imm;
         out_ctrl  <= in_ctrl;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (haz && !flush && (stall_cnt != {CNT_W{1'b1}}))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - scoreboard bench for operand_fetch_stage
module tb_operand_fetch_stage;

   localparam int CTRL_W = 8;
   localparam int CNT_W  = 16;
   localparam int MAXCNT = (1 << CNT_W) - 1;
`ifdef OPFETCH_MEM_FWD_EN
   localparam bit MEM_FWD = 1'b1;
`else
   localparam bit MEM_FWD = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, in_valid, in_ready, in_uses_rs, in_uses_rt;
   logic [4:0]        in_rs, in_rt, in_rd, rf_ra, rf_rb, wb_dr, mem_dr, out_rd;
   logic [31:0]       in_imm, rf_adata, rf_bdata, wb_data, mem_data, out_a, out_b, out_imm;
   logic [CTRL_W-1:0] in_ctrl, out_ctrl;
   logic              wb_en, mem_en, mem_is_load, flush, out_valid, out_ready;
   logic [CNT_W-1:0]  stall_cnt;

   logic [31:0] regs [32];
   assign rf_adata = regs[rf_ra];
   assign rf_bdata = regs[rf_rb];

   operand_fetch_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs(in_rs), .in_rt(in_rt), .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt),
      .in_rd(in_rd), .in_imm(in_imm), .in_ctrl(in_ctrl), .rf_ra(rf_ra), .rf_rb(rf_rb),
      .rf_adata(rf_adata), .rf_bdata(rf_bdata), .wb_en(wb_en), .wb_dr(wb_dr),
      .wb_data(wb_data), .mem_en(mem_en), .mem_dr(mem_dr), .mem_data(mem_data),
      .mem_is_load(mem_is_load), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_imm(out_imm), .out_ctrl(out_ctrl),
      .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic [31:0]       a;
      logic [31:0]       b;
      logic [4:0]        rd;
      logic [31:0]       imm;
      logic [CTRL_W-1:0] ctrl;
   } entry_t;

   typedef struct {
      bit          valid;
      logic [4:0]  dr;
      logic [31:0] data;
      bit          avail;
   } prod_t;

   entry_t sbq [$];
   int     checks = 0;
   int     errors = 0;
   bit     monOn  = 1'b0;
   bit     mValid = 1'b0, mValidNext = 1'b0;
   int     mCnt = 0, mCntNext = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Architectural value of r: youngest in-flight producer wins; an unavailable one blocks
   function automatic void resolve(input logic [4:0] r, output logic [31:0] val, output bit blocked);
      prod_t pl [2];
      bit    found = 1'b0;
      pl[0].valid = mem_en; pl[0].dr = mem_dr; pl[0].data = mem_data;
      pl[0].avail = !mem_is_load && MEM_FWD;
      pl[1].valid = wb_en;  pl[1].dr = wb_dr;  pl[1].data = wb_data;  pl[1].avail = 1'b1;
      val     = regs[r];
      blocked = 1'b0;
      if (r == 5'd0) begin
         val = '0;
      end else begin
         foreach (pl[i]) begin
            if (!found && pl[i].valid && pl[i].dr == r) begin
               if (pl[i].avail) begin
                  val   = pl[i].data;
                  found = 1'b1;
               end else begin
                  blocked = 1'b1;
               end
            end
         end
      end
   endfunction

   task automatic settle();
      logic [31:0] ra, rb;
      bit          blkA, blkB, haz, expRdy, acc;
      #1;
      resolve(in_rs, ra, blkA);
      resolve(in_rt, rb, blkB);
      haz    = in_valid && ((in_uses_rs && blkA) || (in_uses_rt && blkB));
      expRdy = !flush && !haz && (!mValid || out_ready);
      acc    = rst_n && in_valid && expRdy;
      if (!rst_n) begin
         mValidNext = 1'b0;
         mCntNext   = 0;
      end else begin
         chk("in_ready", 32'(in_ready), 32'(expRdy));
         mValidNext = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : mValid;
         mCntNext   = (haz && !flush && mCnt < MAXCNT) ? mCnt + 1 : mCnt;
         if (acc) sbq.push_back('{a: ra, b: rb, rd: in_rd, imm: in_imm, ctrl: in_ctrl});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (wb_en) regs[wb_dr] = wb_data;
      mValid = mValidNext;
      mCnt   = mCntNext;
   endtask

   task automatic idle();
      in_valid = 0; in_uses_rs = 0; in_uses_rt = 0; in_rs = 0; in_rt = 0;
      wb_en = 0; mem_en = 0; mem_is_load = 0; flush = 0; out_ready = 1;
   endtask

   initial begin
      entry_t e;
      forever begin
         @(negedge clk);
         if (monOn) begin
            chk("out_valid", 32'(out_valid), 32'(mValid));
            chk("stall_cnt", 32'(stall_cnt), 32'(mCnt));
            if (mValid) begin
               if (sbq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL sb_empty actual=out_valid expected=no_entry t=%0t", $time);
               end else begin
                  e = sbq[0];
                  chk("out_a", out_a, e.a);
                  chk("out_b", out_b, e.b);
                  chk("out_rd", 32'(out_rd), 32'(e.rd));
                  chk("out_imm", out_imm, e.imm);
                  chk("out_ctrl", 32'(out_ctrl), 32'(e.ctrl));
                  if (out_ready || flush || !rst_n) void'(sbq.pop_front());
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom();
      idle();
      rst_n = 0; in_valid = 1; in_rd = 5'd9; in_imm = 32'h1234; in_ctrl = 8'hA5;
      wb_dr = 0; wb_data = 0; mem_dr = 0; mem_data = 0;
      settle(); tick(); settle(); tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_out_a", out_a, 32'd0);
      chk("rst_out_b", out_b, 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_out_ctrl", 32'(out_ctrl), 32'd0);
      rst_n = 1; idle(); monOn = 1;

      // wb bypass
      regs[5] = 0; in_valid = 1; in_rs = 5; in_uses_rs = 1;
      wb_en = 1; wb_dr = 5; wb_data = 32'hDEADBEEF;
      settle(); tick();
      chk("wb_bypass", out_a, 32'hDEADBEEF);
      idle(); settle(); tick();

      // mem over wb priority
      in_valid = 1; in_rt = 7; in_uses_rt = 1;
      mem_en = 1; mem_dr = 7; mem_data = 32'h11; wb_en = 1; wb_dr = 7; wb_data = 32'h22;
      settle();
      chk("prio_ready", 32'(in_ready), 32'(MEM_FWD));
      tick();
      in_valid = !MEM_FWD; mem_en = 0; wb_dr = 7; wb_data = 32'h11; out_ready = 0;
      settle(); tick();
      chk("prio_valid", 32'(out_valid), 32'd1);
      chk("prio_out_b", out_b, 32'h11);
      idle(); settle(); tick();

      // load-use bubble, then wb forwards
      in_valid = 1; in_rs = 3; in_uses_rs = 1; mem_en = 1; mem_dr = 3; mem_is_load = 1;
      settle();
      chk("loaduse_ready", 32'(in_ready), 32'd0);
      tick();
      chk("loaduse_cnt", 32'(stall_cnt), MEM_FWD ? 32'd1 : 32'd2);
      mem_en = 0; mem_is_load = 0; wb_en = 1; wb_dr = 3; wb_data = 32'hCAFE0003; out_ready = 0;
      settle();
      chk("loaduse_accept", 32'(in_ready), 32'd1);
      tick();
      chk("loaduse_out_a", out_a, 32'hCAFE0003);

      // backpressure then flush
      wb_en = 0; in_rs = 1; in_uses_rs = 0; in_rd = 5'd21; in_imm = 32'h5555;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("bp_ready", 32'(in_ready), 32'd0);
         tick();
         chk("bp_stable_a", out_a, 32'hCAFE0003);
      end
      flush = 1;
      settle();
      chk("flush_ready", 32'(in_ready), 32'd0);
      tick();
      chk("flush_valid", 32'(out_valid), 32'd0);
      idle(); settle(); tick();
      chk("flush_nocap", 32'(out_valid), 32'd0);

      // r0 never forwards
      regs[0] = 32'h77; in_valid = 1; in_rs = 0; in_rt = 0; in_uses_rs = 1;
      wb_en = 1; wb_dr = 0; wb_data = 32'h5;
      settle(); tick();
      chk("r0_out_a", out_a, 32'd0);
      chk("r0_out_b", out_b, 32'd0);
      idle(); settle(); tick();

      // counter saturation
      in_valid = 1; in_rs = 9; in_uses_rs = 1; mem_en = 1; mem_dr = 9; mem_is_load = 1;
      for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
         settle(); tick();
      end
      chk("cnt_saturate", 32'(stall_cnt), 32'(MAXCNT));
      idle(); settle(); tick();

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         in_rs       = 5'($urandom_range(0, 7));
         in_rt       = 5'($urandom_range(0, 7));
         in_uses_rs  = 1'($urandom_range(0, 1));
         in_uses_rt  = 1'($urandom_range(0, 1));
         in_rd       = 5'($urandom());
         in_imm      = $urandom();
         in_ctrl     = CTRL_W'($urandom());
         mem_en      = 1'($urandom_range(0, 1));
         mem_dr      = 5'($urandom_range(0, 7));
         mem_data    = $urandom();
         mem_is_load = ($urandom_range(0, 2) == 0);
         wb_en       = 1'($urandom_range(0, 1));
         wb_dr       = 5'($urandom_range(0, 7));
         wb_data     = $urandom();
         flush       = ($urandom_range(0, 15) == 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         settle(); tick();
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         settle(); tick();
      end
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
